// File: rtl/combo_lock_core.sv
// combo_lock_core: synchronous combination-lock core with N-digit entry,
// retry counting and timed lockout. All buttons are edge-detected on clk.
// Optional build macro: COMBO_LOCK_PROG_EN (programmable code in UNLOCKED).
module combo_lock_core #(
  parameter int DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] SECRET = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_enter,
  input  logic btn_lock,
  output logic [DIGIT_W-1:0] digit_sel,
  output logic [DIGITS*DIGIT_W-1:0] entry,
  output logic [$clog2(DIGITS+1)-1:0] entry_count,
  output logic [1:0] state,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_count,
  output logic lockout_active
);

  localparam int EW = DIGITS * DIGIT_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOCKED   = 2'b00,
    UNLOCKED = 2'b01,
    ERROR    = 2'b10,
    LOCKOUT  = 2'b11
  } lockState_t;

  lockState_t stateQ;
  logic [DIGIT_W-1:0] digitSelQ, selNext;
  logic [EW-1:0] entryQ, entryNext, codeVal;
  logic [CW-1:0] countQ;
  logic [FW-1:0] failQ;
  logic [TW-1:0] timerQ;
  logic upQ, downQ, enterQ, lockQ;
  logic upP, downP, enterP, lockP;
  logic lastDigit;

  assign upP    = btn_up & ~upQ;
  assign downP  = btn_down & ~downQ;
  assign enterP = btn_enter & ~enterQ;
  assign lockP  = btn_lock & ~lockQ;

  // Button level history for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      upQ    <= 1'b0;
      downQ  <= 1'b0;
      enterQ <= 1'b0;
      lockQ  <= 1'b0;
    end else begin
      upQ    <= btn_up;
      downQ  <= btn_down;
      enterQ <= btn_enter;
      lockQ  <= btn_lock;
    end
  end

  // Next digit selector value and shifted entry candidate
  always_comb begin
    selNext = digitSelQ;
    if (upP && !downP) selNext = digitSelQ + DIGIT_W'(1);
    else if (downP && !upP) selNext = digitSelQ - DIGIT_W'(1);
    entryNext = (entryQ << DIGIT_W) | EW'(digitSelQ);
    lastDigit = (countQ == CW'(DIGITS - 1));
  end

`ifdef COMBO_LOCK_PROG_EN
  logic [EW-1:0] codeQ;
  assign codeVal = codeQ;
`else
  assign codeVal = SECRET;
`endif

  // Lock FSM with entry, retry and lockout bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= LOCKED;
      digitSelQ <= '0;
      entryQ    <= '0;
      countQ    <= '0;
      failQ     <= '0;
      timerQ    <= '0;
`ifdef COMBO_LOCK_PROG_EN
      codeQ     <= SECRET;
`endif
    end else begin
      case (stateQ)
        LOCKOUT: begin
          if (timerQ == '0) begin
            stateQ <= LOCKED;
            failQ  <= '0;
            entryQ <= '0;
            countQ <= '0;
          end else begin
            timerQ <= timerQ - TW'(1);
          end
        end
        UNLOCKED: begin
`ifdef COMBO_LOCK_PROG_EN
          digitSelQ <= selNext;
`endif
          if (lockP) begin
            stateQ <= LOCKED;
            entryQ <= '0;
            countQ <= '0;
          end
`ifdef COMBO_LOCK_PROG_EN
          else if (enterP) begin
            entryQ <= entryNext;
            if (lastDigit) begin
              codeQ  <= entryNext;
              countQ <= '0;
            end else begin
              countQ <= countQ + CW'(1);
            end
          end
`endif
        end
        default: begin
          digitSelQ <= selNext;
          if (lockP) begin
            stateQ <= LOCKED;
            entryQ <= '0;
            countQ <= '0;
          end else if (enterP) begin
            entryQ <= entryNext;
            if (lastDigit) begin
              countQ <= '0;
              if (entryNext == codeVal) begin
                stateQ <= UNLOCKED;
                failQ  <= '0;
              end else if (failQ == FW'(MAX_TRIES - 1)) begin
                stateQ <= LOCKOUT;
                failQ  <= FW'(MAX_TRIES);
                timerQ <= TW'(LOCKOUT_CYCLES - 1);
              end else begin
                stateQ <= ERROR;
                failQ  <= failQ + FW'(1);
              end
            end else begin
              countQ <= countQ + CW'(1);
            end
          end
        end
      endcase
    end
  end

  assign digit_sel      = digitSelQ;
  assign entry          = entryQ;
  assign entry_count    = countQ;
  assign state          = stateQ;
  assign fail_count     = failQ;
  assign lockout_active = (stateQ == LOCKOUT);

endmodule

// File: tb/tb_combo_lock_core.sv
// tb_combo_lock_core: directed scenarios plus randomized button traffic,
// checked against a digit-list reference model of the lock.
module tb_combo_lock_core;
  localparam int DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCKOUT_CYCLES = 20;
  localparam logic [15:0] SECRET = 16'h1234;
`ifdef COMBO_LOCK_PROG_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, btnUp = 1'b0, btnDown = 1'b0, btnEnter = 1'b0, btnLock = 1'b0;
  logic [3:0] digitSel;
  logic [15:0] entry;
  logic [2:0] entryCount;
  logic [1:0] state;
  logic [1:0] failCount;
  logic lockoutActive;

  int checks = 0;
  int failures = 0;

  // reference model
  int mSel, mEntry, mCount, mState, mFail, mLeft, mCode;
  bit hU, hD, hE, hL;

  combo_lock_core #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .SECRET(SECRET),
    .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btnUp), .btn_down(btnDown),
    .btn_enter(btnEnter), .btn_lock(btnLock), .digit_sel(digitSel),
    .entry(entry), .entry_count(entryCount), .state(state),
    .fail_count(failCount), .lockout_active(lockoutActive)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model(input bit u, input bit d, input bit e, input bit l, input bit r);
    bit eu, ed, ee, el, acc;
    int oldSel;
    if (r) begin
      mSel = 0; mEntry = 0; mCount = 0; mState = 0; mFail = 0; mLeft = 0;
      mCode = SECRET; hU = 0; hD = 0; hE = 0; hL = 0;
      return;
    end
    eu = u && !hU; ed = d && !hD; ee = e && !hE; el = l && !hL;
    hU = u; hD = d; hE = e; hL = l;
    if (mState == 3) begin
      mLeft--;
      if (mLeft == 0) begin mState = 0; mFail = 0; mEntry = 0; mCount = 0; end
      return;
    end
    acc = (mState != 1) || PROG;
    oldSel = mSel;
    if (acc) begin
      if (eu && !ed) mSel = (mSel + 1) % 16;
      else if (ed && !eu) mSel = (mSel + 15) % 16;
    end
    if (el) begin mState = 0; mEntry = 0; mCount = 0; return; end
    if (!acc || !ee) return;
    mEntry = (mEntry * 16 + oldSel) % 65536;
    mCount++;
    if (mCount == DIGITS) begin
      mCount = 0;
      if (mState == 1) mCode = mEntry;
      else if (mEntry == mCode) begin mState = 1; mFail = 0; end
      else begin
        mFail++;
        if (mFail == MAX_TRIES) begin mState = 3; mLeft = LOCKOUT_CYCLES; end
        else mState = 2;
      end
    end
  endtask

  task automatic tick(input bit u, input bit d, input bit e, input bit l, input bit r);
    rst = r; btnUp = u; btnDown = d; btnEnter = e; btnLock = l;
    @(posedge clk); #1;
    model(u, d, e, l, r);
  endtask

  task automatic doReset();
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic pressEnter(); tick(0, 0, 1, 0, 0); tick(0, 0, 0, 0, 0); endtask
  task automatic pressLock();  tick(0, 0, 0, 1, 0); tick(0, 0, 0, 0, 0); endtask

  task automatic enterDigit(input int v);
    int n;
    n = (v - mSel + 16) % 16;
    for (int i = 0; i < n; i++) begin tick(1, 0, 0, 0, 0); tick(0, 0, 0, 0, 0); end
    pressEnter();
  endtask

  task automatic enterCode(input logic [15:0] c);
    for (int k = 3; k >= 0; k--) enterDigit(int'(c[k*4 +: 4]));
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (digitSel !== 4'h0) begin failures++; $display("FAIL reset_sel got=%0h want=0", digitSel); end
    checks++; if (entry !== 16'h0) begin failures++; $display("FAIL reset_entry got=%0h want=0", entry); end
    checks++; if (entryCount !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", entryCount); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0b want=00", state); end
    checks++; if (failCount !== 2'd0) begin failures++; $display("FAIL reset_fail got=%0d want=0", failCount); end
    checks++; if (lockoutActive !== 1'b0) begin failures++; $display("FAIL reset_lockout got=%0b want=0", lockoutActive); end
    // up held through reset release pulses once on the first cycle after reset
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    checks++; if (digitSel !== 4'h1) begin failures++; $display("FAIL reset_held_up got=%0h want=1", digitSel); end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_unlock();
    doReset();
    enterCode(16'h1234);
    checks++; if (entry !== 16'h1234) begin failures++; $display("FAIL unlock_entry got=%0h want=1234", entry); end
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL unlock_state got=%0b want=01", state); end
    checks++; if (failCount !== 2'd0) begin failures++; $display("FAIL unlock_fail got=%0d want=0", failCount); end
    checks++; if (entryCount !== 3'd0) begin failures++; $display("FAIL unlock_count got=%0d want=0", entryCount); end
    pressLock();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL relock_state got=%0b want=00", state); end
    checks++; if (entry !== 16'h0) begin failures++; $display("FAIL relock_entry got=%0h want=0", entry); end
  endtask

  task automatic test_updown();
    doReset();
    tick(0, 1, 0, 0, 0);
    checks++; if (digitSel !== 4'hF) begin failures++; $display("FAIL down_wrap got=%0h want=f", digitSel); end
    tick(0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    checks++; if (digitSel !== 4'hF) begin failures++; $display("FAIL up_down_same got=%0h want=f", digitSel); end
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(1, 0, 0, 0, 0);
    checks++; if (digitSel !== 4'h0) begin failures++; $display("FAIL held_up got=%0h want=0", digitSel); end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_error_recover();
    doReset();
    enterCode(16'h1235);
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL err_state got=%0b want=10", state); end
    checks++; if (failCount !== 2'd1) begin failures++; $display("FAIL err_fail got=%0d want=1", failCount); end
    enterCode(16'h1234);
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL recover_state got=%0b want=01", state); end
    checks++; if (failCount !== 2'd0) begin failures++; $display("FAIL recover_fail got=%0d want=0", failCount); end
  endtask

  task automatic test_lockout();
    logic [3:0] selHold;
    logic [15:0] entHold;
    int bad;
    doReset();
    enterCode(16'h1111);
    enterCode(16'h2222);
    enterCode(16'h3333);
    // two observations (enter edge, release edge) are already in LOCKOUT
    checks++; if (state !== 2'b11) begin failures++; $display("FAIL lockout_enter got=%0b want=11", state); end
    checks++; if (failCount !== 2'd3) begin failures++; $display("FAIL lockout_fail got=%0d want=3", failCount); end
    selHold = digitSel; entHold = entry;
    bad = 0;
    for (int i = 2; i < LOCKOUT_CYCLES; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checks++;
      if (state !== 2'b11 || lockoutActive !== 1'b1 || digitSel !== selHold || entry !== entHold) begin
        failures++;
        $display("FAIL lockout_hold cyc=%0d state=%0b act=%0b sel=%0h ent=%0h want 11/1/%0h/%0h",
                 i, state, lockoutActive, digitSel, entry, selHold, entHold);
      end
    end
    tick(0, 0, 0, 0, 0);
    checks++; if (state !== 2'b00 || lockoutActive !== 1'b0) begin failures++; $display("FAIL lockout_exit state=%0b act=%0b want 00/0", state, lockoutActive); end
    checks++; if (failCount !== 2'd0 || entry !== 16'h0) begin failures++; $display("FAIL lockout_clear fail=%0d ent=%0h want 0/0", failCount, entry); end
  endtask

  task automatic test_lock_priority();
    doReset();
    enterDigit(1);
    enterDigit(2);
    tick(0, 0, 1, 1, 0);
    checks++; if (entry !== 16'h0 || entryCount !== 3'd0 || state !== 2'b00) begin
      failures++; $display("FAIL lock_prio ent=%0h cnt=%0d state=%0b want 0/0/00", entry, entryCount, state); end
    tick(0, 0, 0, 0, 0);
    enterCode(16'h0000);
    enterCode(16'h0000);
    enterCode(16'h0000);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    checks++; if (state !== 2'b00 || lockoutActive !== 1'b0 || failCount !== 2'd0 || entry !== 16'h0 || entryCount !== 3'd0 || digitSel !== 4'h0) begin
      failures++; $display("FAIL rst_mid_lockout state=%0b act=%0b fail=%0d ent=%0h cnt=%0d sel=%0h want all zero",
                           state, lockoutActive, failCount, entry, entryCount, digitSel); end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_unlocked_entry();
    doReset();
    enterCode(16'h1234);
`ifdef COMBO_LOCK_PROG_EN
    enterCode(16'h9876);
    checks++; if (state !== 2'b01 || entry !== 16'h9876 || entryCount !== 3'd0) begin
      failures++; $display("FAIL prog_load state=%0b ent=%0h cnt=%0d want 01/9876/0", state, entry, entryCount); end
    pressLock();
    enterCode(16'h1234);
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL prog_old_code got=%0b want=10", state); end
    enterCode(16'h9876);
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL prog_new_code got=%0b want=01", state); end
`else
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    pressEnter();
    checks++; if (entry !== 16'h1234 || entryCount !== 3'd0 || digitSel !== 4'h4) begin
      failures++; $display("FAIL unlocked_ignore ent=%0h cnt=%0d sel=%0h want 1234/0/4", entry, entryCount, digitSel); end
`endif
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 399 && mState != 3) enterCode(16'(mCode));
      tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 499) == 0));
      checks++;
      if (digitSel !== 4'(mSel) || entry !== 16'(mEntry) || entryCount !== 3'(mCount) ||
          state !== 2'(mState) || failCount !== 2'(mFail) || lockoutActive !== (mState == 3)) begin
        failures++;
        $display("FAIL random cyc=%0d sel=%0h ent=%0h cnt=%0d st=%0b fail=%0d act=%0b want %0h/%0h/%0d/%0d/%0d/%0d",
                 i, digitSel, entry, entryCount, state, failCount, lockoutActive,
                 mSel, mEntry, mCount, mState, mFail, (mState == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_updown();
    test_error_recover();
    test_lockout();
    test_lock_priority();
    test_unlocked_entry();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/combo_lock_core.md
Name: combo_lock_core

Overview:
Parametrised, fully synchronous combination-lock core. It replaces the separate digit selector, shift register, entry counter and lock FSM, all clocked by the single system clock, with no button-driven clocks. It adds N-digit codes, configurable digit width, retry counting and a timed lockout. It sits between the debounced board buttons and the seven-segment/LED display logic.

Parameters:
DIGITS, 4, number of code digits (>=1)
DIGIT_W, 4, bits per digit; digit values wrap modulo 2**DIGIT_W
SECRET, 16'h1234, reset/fixed code, width DIGITS*DIGIT_W, first-entered digit in MS position
MAX_TRIES, 3, consecutive mismatches that trigger lockout (>=1)
LOCKOUT_CYCLES, 100000000, lockout duration in clk cycles (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
btn_up  input  1  debounced level, increment digit
btn_down  input  1  debounced level, decrement digit
btn_enter  input  1  debounced level, commit current digit
btn_lock  input  1  debounced level, relock / clear entry
digit_sel  output  DIGIT_W  currently selected digit value
entry  output  DIGITS*DIGIT_W  committed digits, newest in LS digit
entry_count  output  $clog2(DIGITS+1)  digits committed in current attempt
state  output  2  00 LOCKED, 01 UNLOCKED, 10 ERROR, 11 LOCKOUT
fail_count  output  $clog2(MAX_TRIES+1)  consecutive mismatches
lockout_active  output  1  high exactly while state==LOCKOUT

Behaviour:
- Reset: digit_sel=0, entry=0, entry_count=0, state=LOCKED, fail_count=0, lockout timer=0, edge-detect history=0.
- Each button gets a rising-edge detector: pulse = level & ~level_q. A held button produces exactly one pulse. A button held through reset release produces a pulse on the first cycle after reset.
- All register updates happen at the clock edge ending the pulse cycle. Outputs show the new values on the next cycle (1-cycle latency).
- Entry-accepting states are LOCKED and ERROR.
  - up pulse: digit_sel+1 mod 2**DIGIT_W.
  - down pulse: digit_sel-1 mod 2**DIGIT_W.
  - up and down in the same cycle: no change.
  - enter pulse: entry <= {entry shifted left by DIGIT_W, digit_sel}, using the pre-update digit_sel. entry_count+1.
- On the enter pulse that brings entry_count to DIGITS, compare the new entry value to the code on the same edge, and set entry_count=0.
  - Match: state=UNLOCKED, fail_count=0.
  - Mismatch, fail_count+1 < MAX_TRIES: state=ERROR, fail_count+1.
  - Mismatch, fail_count+1 == MAX_TRIES: state=LOCKOUT, fail_count=MAX_TRIES, timer=LOCKOUT_CYCLES-1.
- ERROR behaves like LOCKED for entry. It stays ERROR until the next evaluation or a lock pulse.
- lock pulse in LOCKED/ERROR: entry=0, entry_count=0, state=LOCKED. fail_count is kept, and lock takes priority over enter in the same cycle. digit_sel still follows up/down in that cycle.
- UNLOCKED:
  - lock pulse: state=LOCKED, entry=0, entry_count=0.
  - up/down/enter: ignored (see optional feature).
- LOCKOUT:
  - All button pulses are ignored and the timer decrements each cycle.
  - On the cycle the timer is 0: state=LOCKED, fail_count=0, entry=0, entry_count=0. LOCKOUT therefore lasts exactly LOCKOUT_CYCLES cycles.
- digit_sel is never cleared except by rst.
- rst during any state, mid-entry or mid-lockout: full reset values on the next cycle, and any lockout is cancelled.

Optional Feature:
COMBO_LOCK_PROG_EN
- Defined:
  - The code is held in an internal register code_q, reset to SECRET.
  - In UNLOCKED, up/down/enter work as in LOCKED, so the same cycle rules apply.
  - The DIGITS-th enter loads code_q with the new entry and sets entry_count=0. State stays UNLOCKED.
  - A lock pulse mid-programming discards the partial entry and relocks; code_q is unchanged.
- Undefined: the code is the constant SECRET, and up/down/enter are ignored in UNLOCKED.
- Ports are identical in both builds.

Test Plan (DIGITS=4, DIGIT_W=4, SECRET=16'h1234, MAX_TRIES=3, LOCKOUT_CYCLES=20):
- Reset, then enter 1,2,3,4 via up pulses and enter pulses -> entry=16'h1234, state=01, fail_count=0, entry_count=0; lock pulse -> state=00, entry=0.
- From digit_sel=0, one down pulse -> digit_sel=4'hF; up and down held high together for one cycle -> digit_sel unchanged; btn_up held 10 cycles -> +1 only.
- Enter 1,2,3,5 -> state=10, fail_count=1; then enter 1,2,3,4 -> state=01, fail_count=0.
- Three wrong codes -> state=11, lockout_active=1 for exactly 20 cycles with up/enter pulses ignored (digit_sel and entry frozen), then state=00, fail_count=0.
- Enter 1,2 then a lock pulse coincident with enter -> entry=0, entry_count=0, state=00; rst asserted mid-lockout -> state=00, all outputs at reset values next cycle.
- With COMBO_LOCK_PROG_EN: unlock, enter 9,8,7,6, lock, enter 1,2,3,4 -> state=10; enter 9,8,7,6 -> state=01. Without the macro, enter pulses in UNLOCKED leave entry and entry_count unchanged.
